// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bundle of the fetch sequencer's control, memory and status
//               signals.
//               master : fetch_ctrl side (drives PC/IR/status outputs)
//               slave  : decode/execute + instruction memory side
//               Control in : start, stall, halt_req, branch_en, branch_rel,
//                            branch_target
//               Memory     : instr_addr (out), instr_in (in)
//               Status out : instr_out, fetched_pc, instr_valid, done,
//                            wrapped, cycle_count
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
  parameter int PC_W        = 8,
  parameter int INSTR_WIDTH = 9
);
  logic                   start;
  logic                   stall;
  logic                   halt_req;
  logic                   branch_en;
  logic                   branch_rel;
  logic [PC_W-1:0]        branch_target;
  logic [PC_W-1:0]        instr_addr;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_W-1:0]        fetched_pc;
  logic                   instr_valid;
  logic                   done;
  logic                   wrapped;
  logic [15:0]            cycle_count;

  modport master (
    input  start, stall, halt_req, branch_en, branch_rel, branch_target,
    input  instr_in,
    output instr_addr, instr_out, fetched_pc, instr_valid, done, wrapped,
    output cycle_count
  );

  modport slave (
    output start, stall, halt_req, branch_en, branch_rel, branch_target,
    output instr_in,
    input  instr_addr, instr_out, fetched_pc, instr_valid, done, wrapped,
    input  cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the program counter, drives
//               the combinational-read instruction memory address and
//               registers the returned word into the instruction register.
//               Supports start/halt, stalls, absolute/relative branches with
//               a one-slot squash, and PC wrap-around detection.
//               Ports: clk   - rising-edge clock
//                      reset - synchronous, active-high
//                      bus   - fetch_ctrl_if.master (control, memory, status)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter int ROM_SIZE    = 256,
  parameter int INSTR_WIDTH = 9,
  parameter int START_ADDR  = 0
) (
  input  wire logic     clk,
  input  wire logic     reset,
  fetch_ctrl_if.master  bus
);

  localparam int              PC_W     = $clog2(ROM_SIZE);
  localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(ROM_SIZE - 1);
  localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                 state_q,   state_d;
  logic [PC_W-1:0]        pc_q,      pc_d;
  logic [INSTR_WIDTH-1:0] ir_q,      ir_d;
  logic [PC_W-1:0]        fpc_q,     fpc_d;
  logic                   valid_q,   valid_d;
  logic                   done_q,    done_d;
  logic                   wrapped_q, wrapped_d;
  logic [15:0]            cnt_q,     cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_START;
      ir_q      <= '0;
      fpc_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      fpc_q     <= fpc_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    fpc_d     = fpc_q;
    valid_d   = valid_q;
    done_d    = done_q;
    wrapped_d = wrapped_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d   = S_RUN;
          pc_d      = PC_START;
          cnt_d     = '0;
          wrapped_d = 1'b0;
          done_d    = 1'b0;
          valid_d   = 1'b0;
        end
      end

      S_RUN: begin
        // Every RUN cycle counts, including stalled and halting ones.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 16'd1;
        end

        if (bus.halt_req) begin
          state_d = S_HALTED;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (bus.stall) begin
          // Everything holds.
        end else if (bus.branch_en && valid_q) begin
          // Relative target is PC_W-bit modular add, so the offset's sign
          // extension is implicit. The word on instr_in this cycle is
          // discarded (one-slot squash); IR keeps its old contents.
          pc_d    = bus.branch_rel ? (fpc_q + bus.branch_target)
                                   : bus.branch_target;
          valid_d = 1'b0;
        end else begin
          ir_d    = bus.instr_in;
          fpc_d   = pc_q;
          valid_d = 1'b1;
          if (pc_q == PC_LAST) begin
            pc_d      = '0;
            wrapped_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.instr_addr  = pc_q;
  assign bus.instr_out   = ir_q;
  assign bus.fetched_pc  = fpc_q;
  assign bus.instr_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.wrapped     = wrapped_q;
  assign bus.cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. A behavioural model is
//               compared against every output on every falling edge, and
//               directed steps pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic clk;
  logic reset;

  fetch_ctrl_if #(.PC_W(8), .INSTR_WIDTH(9)) bus ();

  fetch_ctrl #(
    .ROM_SIZE    (256),
    .INSTR_WIDTH (9),
    .START_ADDR  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: rom[i] = i.
  logic [8:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
  end
  assign bus.instr_in = rom[bus.instr_addr];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MODE_IDLE = 0, MODE_RUN = 1, MODE_HALTED = 2;
  int         m_mode;
  int         m_pc, m_fpc, m_cnt;
  logic [8:0] m_ir;
  bit         m_valid, m_done, m_wrap;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = MODE_IDLE; m_pc = 0; m_fpc = 0; m_ir = 9'h000;
      m_valid = 0; m_done = 0; m_wrap = 0; m_cnt = 0;
    end else if (m_mode != MODE_RUN) begin
      if (bus.start) begin
        m_mode = MODE_RUN; m_pc = 0; m_cnt = 0;
        m_wrap = 0; m_done = 0; m_valid = 0;
      end
    end else begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (bus.halt_req) begin
        m_mode = MODE_HALTED; m_valid = 0; m_done = 1;
      end else if (bus.stall) begin
        // hold
      end else if (bus.branch_en && m_valid) begin
        if (bus.branch_rel) begin
          int off;
          off  = (bus.branch_target >= 8'd128) ? int'(bus.branch_target) - 256
                                               : int'(bus.branch_target);
          m_pc = (m_fpc + off + 256) % 256;
        end else begin
          m_pc = int'(bus.branch_target);
        end
        m_valid = 0;
      end else begin
        m_ir    = rom[m_pc];
        m_fpc   = m_pc;
        m_valid = 1;
        if (m_pc == 255) m_wrap = 1;
        m_pc = (m_pc + 1) % 256;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_instr_addr",  32'(bus.instr_addr),  32'(m_pc));
      chk("cmp_instr_out",   32'(bus.instr_out),   32'(m_ir));
      chk("cmp_fetched_pc",  32'(bus.fetched_pc),  32'(m_fpc));
      chk("cmp_instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("cmp_done",        32'(bus.done),        32'(m_done));
      chk("cmp_wrapped",     32'(bus.wrapped),     32'(m_wrap));
      chk("cmp_cycle_count", 32'(bus.cycle_count), 32'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  // After tick() all edges so far are visible and inputs may be changed.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  32'(bus.instr_addr),  32'h0);
    chk({tag, "_ir"},    32'(bus.instr_out),   32'h0);
    chk({tag, "_fpc"},   32'(bus.fetched_pc),  32'h0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_done"},  32'(bus.done),        32'h0);
    chk({tag, "_wrap"},  32'(bus.wrapped),     32'h0);
    chk({tag, "_cnt"},   32'(bus.cycle_count), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.stall = 0; bus.halt_req = 0;
    bus.branch_en = 0; bus.branch_rel = 0; bus.branch_target = 8'h00;

    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;

    // Idle with start low.
    for (int i = 0; i < 5; i++) tick();
    chk_reset_vals("idle");

    // Straight-line fetch.
    bus.start = 1; tick(); bus.start = 0;
    chk("run_entry_valid", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("first_ir",  32'(bus.instr_out),  32'h000);
    chk("first_fpc", 32'(bus.fetched_pc), 32'h00);
    tick();
    chk("ir1", 32'(bus.instr_out), 32'h001);
    tick();
    chk("ir2",  32'(bus.instr_out),   32'h002);
    chk("cnt3", 32'(bus.cycle_count), 32'd3);

    // Stall for three cycles.
    bus.stall = 1;
    for (int i = 0; i < 3; i++) tick();
    bus.stall = 0;
    chk("stall_ir",   32'(bus.instr_out),   32'h002);
    chk("stall_addr", 32'(bus.instr_addr),  32'h03);
    chk("stall_cnt",  32'(bus.cycle_count), 32'd6);
    tick();
    chk("post_stall_ir", 32'(bus.instr_out), 32'h003);

    // Absolute branch to the last ROM word, then wrap.
    bus.branch_en = 1; bus.branch_rel = 0; bus.branch_target = 8'hFF;
    tick();
    bus.branch_en = 0;
    chk("abs_bubble", 32'(bus.instr_valid), 32'h0);
    chk("abs_pc",     32'(bus.instr_addr),  32'hFF);
    tick();
    chk("abs_ir", 32'(bus.instr_out), 32'h0FF);
    tick();
    chk("wrap_ir",   32'(bus.instr_out), 32'h000);
    chk("wrap_flag", 32'(bus.wrapped),   32'h1);

    // Advance to fetched_pc = 5, then relative branch by -2.
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rel_fpc", 32'(bus.fetched_pc), 32'h05);
    bus.branch_en = 1; bus.branch_rel = 1; bus.branch_target = 8'hFE;
    tick();
    bus.branch_en = 0; bus.branch_rel = 0;
    chk("rel_bubble", 32'(bus.instr_valid), 32'h0);
    tick();
    chk("rel_ir",  32'(bus.instr_out),  32'h003);
    chk("rel_fpc", 32'(bus.fetched_pc), 32'h03);

    // Halt together with branch and stall: halt wins, no redirect.
    bus.halt_req = 1; bus.stall = 1;
    bus.branch_en = 1; bus.branch_target = 8'h80;
    tick();
    bus.halt_req = 0; bus.stall = 0; bus.branch_en = 0;
    chk("halt_done",  32'(bus.done),        32'h1);
    chk("halt_valid", 32'(bus.instr_valid), 32'h0);
    chk("halt_addr",  32'(bus.instr_addr),  32'h04);
    tick(); tick();
    chk("halted_ir",   32'(bus.instr_out),  32'h003);
    chk("halted_addr", 32'(bus.instr_addr), 32'h04);

    // Restart; a branch while nothing is valid acts as sequential fetch.
    bus.start = 1; tick(); bus.start = 0;
    chk("restart_done", 32'(bus.done),        32'h0);
    chk("restart_cnt",  32'(bus.cycle_count), 32'd0);
    bus.branch_en = 1; bus.branch_target = 8'h40;
    tick();
    bus.branch_en = 0;
    chk("restart_ir",   32'(bus.instr_out),   32'h000);
    chk("restart_addr", 32'(bus.instr_addr),  32'h01);
    chk("restart_cnt1", 32'(bus.cycle_count), 32'd1);

    // start while running is ignored.
    bus.start = 1; tick(); bus.start = 0;
    chk("run_start_cnt", 32'(bus.cycle_count), 32'd2);
    chk("run_start_ir",  32'(bus.instr_out),   32'h001);

    // Reset mid-run, with start asserted at the same time.
    reset = 1; bus.start = 1;
    tick();
    reset = 0; bus.start = 0;
    chk_reset_vals("midrun_reset");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
